// File: rtl/dh_trng_word.sv
// Ring-oscillator TRNG word generator: sync, XOR combine, repetition-count health test, packer.
// Define DH_TRNG_VN_EN to compile in the von Neumann conditioner.
module dh_trng_word #(
    parameter int unsigned NUM_RO     = 12,
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned RCT_CUTOFF = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail
);
    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned BIT_W = $clog2(WORD_W + 1);

    logic [NUM_RO-1:0] r_sync1, r_sync2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic [RUN_W-1:0]  r_run;
    logic              r_health_fail;
    logic [WORD_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bits;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_valid;

    logic w_raw, w_strobe, w_bit, w_bit_valid;
    logic w_full, w_out_free, w_load, w_fail_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw    = ^r_sync2;
    assign w_strobe = en && (r_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || w_strobe) r_cnt <= '0;
        else                        r_cnt <= r_cnt + CNT_W'(1);
    end

    // Run state is deliberately not cleared by en so the test spans enable gaps.
    assign w_fail_set = (r_run == RUN_W'(RCT_CUTOFF));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last        <= 1'b0;
            r_run         <= '0;
            r_health_fail <= 1'b0;
        end else begin
            if (w_strobe) begin
                r_last <= w_raw;
                if (r_run != '0 && w_raw == r_last) begin
                    if (!w_fail_set) r_run <= r_run + RUN_W'(1);
                end else begin
                    r_run <= RUN_W'(1);
                end
            end
            if (w_fail_set) r_health_fail <= 1'b1;
        end
    end

`ifdef DH_TRNG_VN_EN
    logic r_vn_have, r_vn_first;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_vn_have  <= 1'b0;
            r_vn_first <= 1'b0;
        end else if (w_strobe) begin
            r_vn_have <= !r_vn_have;
            if (!r_vn_have) r_vn_first <= w_raw;
        end
    end

    // Pair (a,b) with a!=b emits a: 10 -> 1, 01 -> 0.
    assign w_bit_valid = w_strobe && r_vn_have && (r_vn_first != w_raw);
    assign w_bit       = r_vn_first;
`else
    assign w_bit_valid = w_strobe;
    assign w_bit       = w_raw;
`endif

    assign w_full     = (r_bits == BIT_W'(WORD_W));
    assign w_out_free = !r_out_valid || out_ready;
    assign w_load     = w_full && w_out_free && !r_health_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bits      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_data  <= r_shift;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_health_fail || w_fail_set) r_out_valid <= 1'b0;

            // A full shifter survives en=0; only a partial word is discarded.
            if (w_load) begin
                if (w_bit_valid) begin
                    r_shift <= {r_shift[WORD_W-2:0], w_bit};
                    r_bits  <= BIT_W'(1);
                end else begin
                    r_bits  <= '0;
                end
            end else if (!en && !w_full) begin
                r_bits <= '0;
            end else if (w_bit_valid && !w_full) begin
                r_shift <= {r_shift[WORD_W-2:0], w_bit};
                r_bits  <= r_bits + BIT_W'(1);
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign health_fail = r_health_fail;
endmodule

// File: tb/tb_dh_trng_word.sv
// Directed scoreboard bench for dh_trng_word (default parameters, either DH_TRNG_VN_EN setting).
module tb_dh_trng_word;
    logic        clk = 1'b0;
    logic        rst, en, out_ready, health_fail, out_valid;
    logic [11:0] ro_in;
    logic [7:0]  out_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  q[$];

    dh_trng_word #(
        .NUM_RO(12), .WORD_W(8), .SAMPLE_DIV(4), .RCT_CUTOFF(32)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ro_in(ro_in),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word scoreboard: compare on every accepted handshake.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) check("word_unexpected", {24'h0, out_data}, 32'hxxxx_xxxx);
            else               check("word", {24'h0, out_data}, {24'h0, q.pop_front()});
        end
    end

    // One raw sample: random ro_in with parity b, held for one sample window.
    task automatic drive_sample(input logic b);
        logic [11:0] v;
        v = 12'($urandom);
        if ((^v) != b) v[0] = ~v[0];
        ro_in = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
`ifdef DH_TRNG_VN_EN
        drive_sample(b);
        drive_sample(!b);
`else
        drive_sample(b);
`endif
    endtask

    task automatic send_word(input logic [7:0] w, input logic push);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        if (push) q.push_back(w);
    endtask

    task automatic drain();
        en = 1'b0;
        for (int i = 0; i < 64 && q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("drain_valid", {31'h0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; ro_in = '0;
        repeat (3) @(negedge clk);
        check("rst_data",   {24'h0, out_data}, 32'd0);
        check("rst_valid",  {31'h0, out_valid}, 32'd0);
        check("rst_health", {31'h0, health_fail}, 32'd0);

        // Alternating raw patterns, then random words.
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
`ifdef DH_TRNG_VN_EN
        send_word(8'hFF, 1'b1);
        send_word(8'h00, 1'b1);
        // 11/00 pairs must contribute nothing.
        for (int i = 7; i >= 0; i--) begin
            drive_sample(i[0]);
            drive_sample(i[0]);
            w = 8'hA5;
            send_bit(w[i]);
        end
        q.push_back(8'hA5);
`else
        send_word(8'hAA, 1'b1);
        send_word(8'h55, 1'b1);
`endif
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom_range(0, 255));
            send_word(w, 1'b1);
        end
        drain();
        check("pattern_health", {31'h0, health_fail}, 32'd0);

        // Back-pressure: two words produced, third discarded.
        out_ready = 1'b0; en = 1'b1;
        send_word(8'h3C, 1'b1);
        send_word(8'hC5, 1'b1);
        send_word(8'h99, 1'b0);
        en = 1'b0;
        check("bp_data1",  {24'h0, out_data}, 32'h3C);
        check("bp_valid1", {31'h0, out_valid}, 32'd1);
        repeat (5) @(negedge clk);
        check("bp_stable", {24'h0, out_data}, 32'h3C);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_data2",  {24'h0, out_data}, 32'hC5);
        check("bp_valid2", {31'h0, out_valid}, 32'd1);
        repeat (6) @(negedge clk);
        check("bp_no_third", {24'h0, out_data}, 32'hC5);
        check("bp_valid3",   {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        drain();

        // en dropped mid-word with a pending word.
        out_ready = 1'b0; en = 1'b1;
        send_word(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("en_pend_data",  {24'h0, out_data}, 32'h5A);
        check("en_pend_valid", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        drain();
        en = 1'b1;
        send_word(8'h81, 1'b1);
        drain();

        // Reset mid-word with a pending word.
        out_ready = 1'b0; en = 1'b1;
        send_word(8'h66, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_data",   {24'h0, out_data}, 32'd0);
        check("mid_rst_valid",  {31'h0, out_valid}, 32'd0);
        check("mid_rst_health", {31'h0, health_fail}, 32'd0);
        rst = 1'b0;
        send_word(8'h4B, 1'b1);
        drain();

        // Repetition-count failure on constant all-zero input.
        out_ready = 1'b0; en = 1'b1;
`ifdef DH_TRNG_VN_EN
        send_word(8'hFE, 1'b0);
        w = 8'hFE;
`else
        send_word(8'h01, 1'b0);
        w = 8'h01;
`endif
        ro_in = '0;
        repeat (31 * 4) @(negedge clk);
        check("rct_31_health", {31'h0, health_fail}, 32'd0);
        check("rct_31_valid",  {31'h0, out_valid}, 32'd1);
        check("rct_31_data",   {24'h0, out_data}, {24'h0, w});
        repeat (4) @(negedge clk);
        check("rct_32_health", {31'h0, health_fail}, 32'd0);
        @(negedge clk);
        check("rct_fail_health", {31'h0, health_fail}, 32'd1);
        check("rct_fail_valid",  {31'h0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) drive_sample(i[0]);
        check("rct_sticky",        {31'h0, health_fail}, 32'd1);
        check("rct_blocked_valid", {31'h0, out_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rct_rst_health", {31'h0, health_fail}, 32'd0);
        rst = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
